// File: rtl/vdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : vdiv_seq
// Description : Sequential radix-2 restoring divider, signed/unsigned,
//               fixed N+2 cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vdiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] quo_o,
    output logic [DATA_WIDTH-1:0] rem_o
);

    localparam int c_N  = DATA_WIDTH;
    localparam int c_CW = $clog2(c_N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_CW-1:0]   r_cnt;
    logic [c_N-1:0]    r_quo;
    logic [c_N-1:0]    r_rem;
    logic [c_N-1:0]    r_bmag;
    logic [c_N-1:0]    r_a;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_bzero;
    logic              r_ovf;
    logic [c_N-1:0]    r_quo_o;
    logic [c_N-1:0]    r_rem_o;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [c_N-1:0]    w_a_mag;
    logic [c_N-1:0]    w_b_mag;
    logic [c_N:0]      w_shift;
    logic [c_N:0]      w_diff;
    logic              w_ge;

    assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_neg  = signed_i & a_i[c_N-1];
    assign w_b_neg  = signed_i & b_i[c_N-1];
    assign w_a_mag  = w_a_neg ? (~a_i + 1'b1) : a_i;
    assign w_b_mag  = w_b_neg ? (~b_i + 1'b1) : b_i;

    // Partial remainder stays below the divisor, so bit N of the difference
    // is a clean borrow flag whenever the divisor is non-zero.
    assign w_shift  = {r_rem, r_quo[c_N-1]};
    assign w_diff   = w_shift - {1'b0, r_bmag};
    assign w_ge     = ~w_diff[c_N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == c_CW'(1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = start_i ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_bmag  <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
            r_ovf   <= 1'b0;
            r_quo_o <= '0;
            r_rem_o <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_CW'(c_N);
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_bmag  <= w_b_mag;
            r_a     <= a_i;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bzero <= (b_i == '0);
            r_ovf   <= signed_i && (a_i == {1'b1, {(c_N-1){1'b0}}}) && (&b_i);
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - 1'b1;
            r_quo <= {r_quo[c_N-2:0], w_ge};
            r_rem <= w_ge ? w_diff[c_N-1:0] : w_shift[c_N-1:0];
        end else if (r_state == S_FIX) begin
            if (r_bzero) begin
                r_quo_o <= '1;
                r_rem_o <= r_a;
            end else if (r_ovf) begin
                r_quo_o <= r_a;
                r_rem_o <= '0;
            end else begin
                r_quo_o <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                r_rem_o <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
            end
        end
    end

    assign busy_o  = (r_state == S_CALC) || (r_state == S_FIX);
    assign valid_o = (r_state == S_DONE);
    assign quo_o   = r_quo_o;
    assign rem_o   = r_rem_o;

endmodule
`default_nettype wire
